// File: rtl/trig_multi.sv
// Oscilloscope trigger unit: selects one asynchronous channel, synchronises and
// glitch-filters it, detects the chosen edge and runs the arm/trigger/holdoff sequence.
module trig_multi #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 1,
    parameter int TMO_W       = 16,
    parameter int HOLD_W      = 16,
    localparam int SRC_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [SRC_W-1:0]  trig_src,
    input  logic [1:0]        trig_edge,
    input  logic              trig_en,
    input  logic              armed,
    input  logic              force_trig,
    input  logic              auto_en,
    input  logic [TMO_W-1:0]  auto_timeout,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              set_capture_done,
    output logic              triggered,
    output logic              trig_auto,
    output logic [1:0]        trig_state
);

    localparam int CNT_W = $clog2(FILT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_TRIG  = 2'b10,
        S_HOLD  = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [SRC_W-1:0]  src_q;
    logic              filt_q, filt_d;
    logic              filt_dly_q, filt_dly_d;
    logic [CNT_W-1:0]  filt_cnt_q, filt_cnt_d;
    state_t            state_q, state_d;
    logic [TMO_W-1:0]  auto_cnt_q, auto_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              trig_auto_q, trig_auto_d;
    logic              triggered_q;

    logic [SRC_W-1:0]  ch_sel;
    logic              sel;
    logic              src_chg;
    logic              edge_raw;
    logic              edge_hit;
    logic              auto_fire;

    // Out-of-range selects fall back to channel 0.
    assign ch_sel  = ({1'b0, trig_src} < (SRC_W+1)'(NUM_CH)) ? trig_src : '0;
    assign sel     = sync_q[SYNC_STAGES-1][ch_sel];
    assign src_chg = (trig_src != src_q);

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], trig_in};
        filt_d     = filt_q;
        filt_dly_d = filt_q;
        filt_cnt_d = filt_cnt_q;
        if (src_chg) begin
            // Preload both filter stages so the switch itself cannot look like an edge.
            filt_d     = sel;
            filt_dly_d = sel;
            filt_cnt_d = '0;
        end else if (sel == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == CNT_W'(FILT_CYCLES - 1)) begin
            filt_d     = sel;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (trig_edge)
            2'b01:   edge_raw = ~filt_q & filt_dly_q;
            2'b10:   edge_raw = filt_q ^ filt_dly_q;
            default: edge_raw = filt_q & ~filt_dly_q;
        endcase
        edge_hit = edge_raw & ~src_chg;
    end

    assign auto_fire = auto_en && (auto_timeout != '0) &&
                       (auto_cnt_q == auto_timeout - TMO_W'(1));

    always_comb begin
        state_d     = state_q;
        auto_cnt_d  = auto_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        trig_auto_d = trig_auto_q;
        case (state_q)
            S_IDLE: begin
                if (trig_en && armed) begin
                    state_d    = S_ARMED;
                    auto_cnt_d = '0;
                end
            end
            S_ARMED: begin
                if (!trig_en || !armed) begin
                    state_d = S_IDLE;
                end else if (edge_hit) begin
                    state_d     = S_TRIG;
                    trig_auto_d = 1'b0;
                end else if (force_trig || auto_fire) begin
                    state_d     = S_TRIG;
                    trig_auto_d = 1'b1;
                end else if (auto_en && (auto_cnt_q != '1)) begin
                    auto_cnt_d = auto_cnt_q + TMO_W'(1);
                end
            end
            S_TRIG: begin
                // Capture in progress: only capture completion leaves this state.
                if (set_capture_done) begin
                    if (holdoff == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_HOLD;
                        hold_cnt_d = holdoff - HOLD_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) state_d = S_IDLE;
                else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            src_q       <= '0;
            filt_q      <= 1'b0;
            filt_dly_q  <= 1'b0;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            auto_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            trig_auto_q <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            src_q       <= trig_src;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_dly_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            auto_cnt_q  <= auto_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            trig_auto_q <= trig_auto_d;
            triggered_q <= (state_d == S_TRIG);
        end
    end

    assign triggered  = triggered_q;
    assign trig_auto  = trig_auto_q;
    assign trig_state = state_q;

endmodule

// File: doc/trig_multi.md
Name: trig_multi

Overview:
- Next-generation oscilloscope trigger unit.
- Selects one of NUM_CH asynchronous digital trigger inputs, synchronises it, glitch-filters it and detects rising, falling or either edge.
- Sequences IDLE/ARMED/TRIGGERED/HOLDOFF, adding forced trigger, auto-trigger timeout and post-capture holdoff.
- Sits between the front-end trigger comparators and the capture/RAM write controller.

Parameters:
- NUM_CH, 4, number of trigger input channels (>=2).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_CYCLES, 1, consecutive cycles a new level must persist before it is accepted (>=1).
- TMO_W, 16, width of the auto-trigger timeout.
- HOLD_W, 16, width of the holdoff count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- trig_in  in  NUM_CH  asynchronous trigger levels.
- trig_src  in  clog2(NUM_CH)  channel select; values >= NUM_CH select channel 0.
- trig_edge  in  2  00 rise, 01 fall, 10 either, 11 treated as rise.
- trig_en  in  1  trigger enable.
- armed  in  1  capture pre-trigger fill complete.
- force_trig  in  1  single-cycle software force.
- auto_en  in  1  enable auto-trigger.
- auto_timeout  in  TMO_W  auto-trigger timeout in cycles; 0 disables auto.
- holdoff  in  HOLD_W  holdoff cycles after capture done.
- set_capture_done  in  1  capture finished pulse.
- triggered  out  1  high while in TRIGGERED.
- trig_auto  out  1  last trigger came from force or auto.
- trig_state  out  2  00 IDLE, 01 ARMED, 10 TRIGGERED, 11 HOLDOFF.

Behaviour:
- Reset: all sync flops, filter level, filter delay and counters = 0; state IDLE; triggered = 0; trig_auto = 0; trig_state = 00.
- Synchroniser: each channel has a SYNC_STAGES flop chain; sel = last stage of the selected channel.
- Filter counter: sel == filt -> cnt <= 0. Otherwise, cnt == FILT_CYCLES-1 -> filt <= sel and cnt <= 0; else cnt++.
- Source change: trig_src != trig_src_q -> filt and filt_q load sel, cnt <= 0; no edge is generated that cycle.
- Edge detect: filt_q <= filt each cycle. edge_hit is combinational: rise = filt & ~filt_q, fall = ~filt & filt_q, either = filt ^ filt_q.
- Latency: with defaults, trig_in rising sampled at edge 0 -> triggered high after edge 3 (SYNC_STAGES + FILT_CYCLES + 1 edges total).
- IDLE -> ARMED: trig_en & armed. On entry, auto counter is cleared.
- ARMED, priority order (highest first):
  - !trig_en | !armed -> IDLE.
  - edge_hit -> TRIGGERED, trig_auto <= 0.
  - force_trig -> TRIGGERED, trig_auto <= 1.
  - auto_en & auto_timeout != 0 & auto_cnt == auto_timeout-1 -> TRIGGERED, trig_auto <= 1.
  - Otherwise auto_cnt++ when auto_en.
- Edges and force pulses in IDLE, TRIGGERED or HOLDOFF are ignored and never queued.
- TRIGGERED:
  - Latches; trig_en / armed deassertion has no effect (capture in progress).
  - set_capture_done with holdoff == 0 -> IDLE.
  - set_capture_done with holdoff != 0 -> HOLDOFF, hold_cnt <= holdoff-1.
- HOLDOFF: hold_cnt == 0 -> IDLE; else hold_cnt--. The state lasts exactly holdoff cycles. set_capture_done is ignored.
- set_capture_done outside TRIGGERED is ignored.
- triggered and trig_state are registered decodes of state; no combinational path from inputs.
- trig_auto holds its value until the next trigger.
- Async reset mid-capture or mid-holdoff returns to IDLE immediately; triggered drops without waiting for a clock.
- The auto counter saturates, never wraps. It is only compared while in ARMED.

Test Plan:
- Basic edge: defaults, trig_src=2, trig_edge=00, trig_en=armed=1; raise trig_in[2] at edge 0 -> triggered=1 after edge 3, trig_auto=0; set_capture_done with holdoff=0 -> triggered=0 next cycle, state IDLE.
- Glitch filter: FILT_CYCLES=3; 2-cycle pulse on the selected channel -> no trigger. A 3-cycle pulse -> trigger. trig_edge=01 triggers only on the falling level.
- Either edge and source switch: trig_edge=10, both edges trigger; switching trig_src between channels at different levels -> no spurious trigger.
- Auto/force: auto_en=1, auto_timeout=100, no edges -> triggered after exactly 100 cycles in ARMED with trig_auto=1. force_trig at cycle 10 -> trigger next cycle with trig_auto=1. Simultaneous edge+force -> trig_auto=0.
- Holdoff: holdoff=5, set_capture_done in TRIGGERED -> trig_state=11 for exactly 5 cycles, then IDLE. Edges during holdoff ignored; re-arm only afterwards.
- Disarm/reset: drop armed in ARMED -> IDLE. Drop trig_en in TRIGGERED -> stays triggered. rst_n low mid-TRIGGERED -> all outputs 0 asynchronously.
